// File: rtl/pipe_barrel_shifter.sv
// Pipelined log-depth barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control.
// Produces carry-out and zero flags; a register bank follows every PIPE_EVERY mux levels.
module pipe_barrel_shifter #(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 2,
  localparam int LOG2W     = $clog2(WIDTH),
  localparam int NREG      = (LOG2W + PIPE_EVERY - 1) / PIPE_EVERY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [LOG2W-1:0] SHAMT_ONE = LOG2W'(1);

  // One mux level: shift by 2^k; SRA keeps the sign because the MSB survives every level.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] op,
                                                   input int k);
    case (op)
      OP_SLL:  shift_level = d << (1 << k);
      OP_SRL:  shift_level = d >> (1 << k);
      OP_SRA:  shift_level = WIDTH'($signed(d) >>> (1 << k));
      default: shift_level = (d >> (1 << k)) | (d << (WIDTH - (1 << k)));
    endcase
  endfunction

  logic             stall;
  logic             carry0;
  logic [LOG2W-1:0] idx_left;
  logic [LOG2W-1:0] idx_right;
  logic [WIDTH-1:0] stage;

  logic [WIDTH-1:0] src_data  [NREG];
  logic [LOG2W-1:0] src_shamt [NREG];
  logic [1:0]       src_op    [NREG];
  logic             src_carry [NREG];
  logic             src_valid [NREG];
  logic [WIDTH-1:0] mux_data  [NREG];

  logic [WIDTH-1:0] data_q    [NREG];
  logic [LOG2W-1:0] shamt_q   [NREG];
  logic [1:0]       op_q      [NREG];
  logic             carry_q   [NREG];
  logic             valid_q   [NREG];
  logic             zero_q;

  assign stall    = valid_q[NREG-1] & ~out_ready;
  assign in_ready = ~stall;

  // Carry is the last bit to leave the word; for ROR that is also the new MSB, in_data[shamt-1].
  assign idx_left  = ~in_shamt + SHAMT_ONE;
  assign idx_right = in_shamt - SHAMT_ONE;

  always_comb begin
    carry0 = 1'b0;
    if (in_shamt != '0) begin
      if (in_op == OP_SLL) carry0 = in_data[idx_left];
      else                 carry0 = in_data[idx_right];
    end
  end

  always_comb begin
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op;
    src_carry[0] = carry0;
    src_valid[0] = in_valid;
    for (int b = 1; b < NREG; b++) begin
      src_data[b]  = data_q[b-1];
      src_shamt[b] = shamt_q[b-1];
      src_op[b]    = op_q[b-1];
      src_carry[b] = carry_q[b-1];
      src_valid[b] = valid_q[b-1];
    end
  end

  // Bank b owns mux levels b*PIPE_EVERY .. b*PIPE_EVERY+PIPE_EVERY-1.
  always_comb begin
    stage = '0;
    for (int b = 0; b < NREG; b++) begin
      stage = src_data[b];
      for (int k = 0; k < LOG2W; k++) begin
        if ((k / PIPE_EVERY) == b && src_shamt[b][k]) stage = shift_level(stage, src_op[b], k);
      end
      mux_data[b] = stage;
    end
  end

  // All banks advance or hold together; invalid beats still flow as bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NREG; b++) begin
        data_q[b]  <= '0;
        shamt_q[b] <= '0;
        op_q[b]    <= '0;
        carry_q[b] <= 1'b0;
        valid_q[b] <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int b = 0; b < NREG; b++) begin
        data_q[b]  <= mux_data[b];
        shamt_q[b] <= src_shamt[b];
        op_q[b]    <= src_op[b];
        carry_q[b] <= src_carry[b];
        valid_q[b] <= src_valid[b];
      end
      zero_q <= (mux_data[NREG-1] == '0);
    end
  end

  assign out_valid = valid_q[NREG-1];
  assign out_data  = data_q[NREG-1];
  assign out_carry = carry_q[NREG-1];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter: directed vector table plus
// streaming, bubble, back-pressure and mid-stream reset sequences.
module tb_pipe_barrel_shifter;

  localparam int WIDTH      = 32;
  localparam int PIPE_EVERY = 2;
  localparam int LOG2W      = 5;
  localparam int NREG       = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LOG2W-1:0] in_shamt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  always #5 clk = ~clk;

  pipe_barrel_shifter #(.WIDTH(WIDTH), .PIPE_EVERY(PIPE_EVERY)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  op;
    logic [31:0] expData;
    logic        expCarry;
    logic        expZero;
  } vec_t;

  vec_t        vecs[15];
  logic [33:0] expq[$];
  logic        accHist[64];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          inCount;
  int          outCount;

  // Bit-by-bit reference: each result bit picks its source bit directly.
  function automatic logic [33:0] refShift(input logic [31:0] d, input logic [4:0] s,
                                           input logic [1:0] op);
    logic [31:0] r;
    logic        c;
    int          src;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      case (op)
        2'b00: begin src = i - int'(s); r[i] = (src >= 0) ? d[src] : 1'b0; end
        2'b01: begin src = i + int'(s); r[i] = (src < 32) ? d[src] : 1'b0; end
        2'b10: begin src = i + int'(s); r[i] = (src < 32) ? d[src] : d[31]; end
        default: r[i] = d[(i + int'(s)) % 32];
      endcase
    end
    if (s == 5'd0)        c = 1'b0;
    else if (op == 2'b00) c = d[32 - int'(s)];
    else if (op == 2'b11) c = r[31];
    else                  c = d[int'(s) - 1];
    return {(r == 32'h0), c, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] s,
                               input logic [1:0] op, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_shamt  = s;
    in_op     = op;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of scoreboarded traffic; results are compared at their output handshake.
  task automatic runCycle(input logic v, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] op, input logic ordy,
                          output logic accIn, output logic accOut);
    logic [33:0] e;
    applyStimulus(v, d, s, op, ordy);
    #1;
    accIn  = v && in_ready;
    accOut = out_valid && ordy;
    if (accOut) begin
      if (expq.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_result: got 0x%08h, expected no result", out_data);
      end else begin
        e = expq.pop_front();
        checkOutput("stream_data", out_data, e[31:0]);
        checkOutput("stream_carry", {31'b0, out_carry}, {31'b0, e[32]});
        checkOutput("stream_zero", {31'b0, out_zero}, {31'b0, e[33]});
        outCount++;
      end
    end
    if (accIn) begin
      expq.push_back(refShift(d, s, op));
      inCount++;
    end
    tick();
  endtask

  function automatic logic [31:0] beatData(input int i);
    return (32'h1357_9BDF * (i + 1)) ^ (32'hA5A5_0000 >> i);
  endfunction

  initial begin
    int lat;
    int firstOut;
    int lastOut;
    int idx;
    int stale;
    logic ai;
    logic ao;

    vecs[0]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_00FF, 5'd4,  2'b01, 32'h0000_000F, 1'b1, 1'b0};
    vecs[2]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000, 1'b1, 1'b0};
    vecs[4]  = '{32'h8000_0000, 5'd1,  2'b00, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[7]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[8]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[9]  = '{32'h7000_0000, 5'd31, 2'b10, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456, 1'b0, 1'b0};
    vecs[11] = '{32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001, 1'b1, 1'b0};
    vecs[12] = '{32'h0000_000F, 5'd3,  2'b00, 32'h0000_0078, 1'b0, 1'b0};
    vecs[13] = '{32'hF000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[14] = '{32'h8000_0001, 5'd31, 2'b11, 32'h0000_0003, 1'b0, 1'b0};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset_out_data", out_data, 32'h0);
    checkOutput("reset_out_carry", {31'b0, out_carry}, 32'h0);
    checkOutput("reset_out_zero", {31'b0, out_zero}, 32'h0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h1);

    // Directed vectors, one beat at a time, with latency measured per beat.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, vecs[i].d, vecs[i].s, vecs[i].op, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
      lat = 1;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      checkOutput($sformatf("vec%0d_latency", i), lat, NREG);
      checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d_carry", i), {31'b0, out_carry}, {31'b0, vecs[i].expCarry});
      checkOutput($sformatf("vec%0d_zero", i), {31'b0, out_zero}, {31'b0, vecs[i].expZero});
      tick();
    end

    // Eight back-to-back beats must emerge on eight consecutive cycles.
    inCount = 0; outCount = 0; idx = 0; firstOut = -1; lastOut = -1;
    for (int c = 0; c < 30; c++) begin
      if (idx < 8) runCycle(1'b1, beatData(idx), 5'((idx * 7) % 32), 2'(idx % 4), 1'b1, ai, ao);
      else         runCycle(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, ai, ao);
      if (ai) idx++;
      if (ao) begin
        if (firstOut < 0) firstOut = c;
        lastOut = c;
      end
    end
    checkOutput("b2b_count", outCount, 8);
    checkOutput("b2b_consecutive", lastOut - firstOut, 7);
    checkOutput("b2b_queue_empty", expq.size(), 0);

    // Alternating in_valid: the bubble pattern must reappear NREG-1 edges later.
    inCount = 0; outCount = 0; idx = 0;
    for (int c = 0; c < 24; c++) begin
      if (idx < 8 && (c % 2) == 0)
        runCycle(1'b1, beatData(idx + 20), 5'((idx * 5 + 1) % 32), 2'((idx + 1) % 4), 1'b1, ai, ao);
      else
        runCycle(1'b0, 32'hFFFF_0000, 5'd3, 2'b01, 1'b1, ai, ao);
      if (ai) idx++;
      accHist[c] = ai;
      if (c >= NREG - 1)
        checkOutput($sformatf("bubble_valid_c%0d", c), {31'b0, out_valid}, {31'b0, accHist[c-(NREG-1)]});
    end
    checkOutput("bubble_count", outCount, 8);

    // Back-pressure: fill the pipe, stall five cycles, then drain.
    inCount = 0; outCount = 0; idx = 0;
    for (int c = 0; c < 60; c++) begin
      if (idx < 10) runCycle(1'b1, beatData(idx + 40), 5'((idx * 3 + 2) % 32), 2'(idx % 4), (c >= 8), ai, ao);
      else          runCycle(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, ai, ao);
      if (ai) idx++;
      if (c >= 2 && c <= 7) begin
        checkOutput($sformatf("stall_in_ready_c%0d", c), {31'b0, in_ready}, 32'h0);
        checkOutput($sformatf("stall_out_valid_c%0d", c), {31'b0, out_valid}, 32'h1);
        checkOutput($sformatf("stall_out_data_c%0d", c), out_data, (expq.size() > 0) ? expq[0][31:0] : 32'hBAD0_BAD0);
      end
    end
    checkOutput("stall_in_count", inCount, 10);
    checkOutput("stall_out_count", outCount, 10);
    checkOutput("stall_queue_empty", expq.size(), 0);

    // Mid-stream reset with three beats held in the pipe.
    inCount = 0; outCount = 0;
    for (int c = 0; c < 3; c++)
      runCycle(1'b1, beatData(c + 60), 5'(c + 9), 2'b10, 1'b0, ai, ao);
    applyStimulus(1'b1, 32'hCAFE_F00D, 5'd4, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expq.delete();
    #1;
    checkOutput("rst_mid_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_mid_in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("rst_mid_out_data", out_data, 32'h0);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      runCycle(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, ai, ao);
      if (out_valid) stale++;
    end
    checkOutput("rst_no_stale", stale, 0);
    outCount = 0;
    runCycle(1'b1, 32'h8000_00F0, 5'd4, 2'b10, 1'b1, ai, ao);
    for (int c = 0; c < 8; c++)
      runCycle(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, ai, ao);
    checkOutput("rst_next_beat_count", outCount, 1);
    checkOutput("rst_model_check", refShift(32'h8000_00F0, 5'd4, 2'b10), {1'b0, 1'b0, 32'hF800_000F});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
